// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU.
// Result is {remainder, quotient}; ready holds until start drops.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start_i,
  input  logic        div_annul_i,
  input  logic        div_signed_i,
  input  logic [31:0] div_oprd1_i,
  input  logic [31:0] div_oprd2_i,
  output logic [63:0] div_result_o,
  output logic        div_ready_o
);

  localparam logic [1:0] ST_FREE    = 2'b00;
  localparam logic [1:0] ST_DIVZERO = 2'b01;
  localparam logic [1:0] ST_ON      = 2'b10;
  localparam logic [1:0] ST_END     = 2'b11;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [64:0] w;
  logic [31:0] dvsr;
  logic        neg_q;
  logic        neg_r;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [33:0] trial;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  always_comb begin
    a_mag = div_oprd1_i;
    b_mag = div_oprd2_i;
    if (div_signed_i && div_oprd1_i[31])
      a_mag = -div_oprd1_i;
    if (div_signed_i && div_oprd2_i[31])
      b_mag = -div_oprd2_i;
  end

  // Shifted partial remainder minus divisor; bit 33 is the borrow.
  assign trial = w[64:31] - {2'b00, dvsr};

  assign q_fix = neg_q ? -w[31:0]  : w[31:0];
  assign r_fix = neg_r ? -w[63:32] : w[63:32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_FREE;
      cnt          <= 5'd0;
      w            <= 65'd0;
      dvsr         <= 32'd0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div_ready_o  <= 1'b0;
      div_result_o <= 64'd0;
    end else begin
      unique case (state)
        ST_FREE: begin
          if (div_start_i && !div_annul_i) begin
            w     <= {33'd0, a_mag};
            dvsr  <= b_mag;
            cnt   <= 5'd0;
            neg_q <= div_signed_i &&
                     (div_oprd1_i[31] ^ div_oprd2_i[31]);
            neg_r <= div_signed_i && div_oprd1_i[31];
            if (div_oprd2_i == 32'd0)
              state <= ST_DIVZERO;
            else
              state <= ST_ON;
          end
        end
        ST_DIVZERO: begin
          w <= 65'd0;
          if (div_annul_i)
            state <= ST_FREE;
          else
            state <= ST_END;
        end
        ST_ON: begin
          if (div_annul_i) begin
            state <= ST_FREE;
            w     <= 65'd0;
            cnt   <= 5'd0;
          end else begin
            if (!trial[33])
              w <= {trial[32:0], w[30:0], 1'b1};
            else
              w <= {w[63:0], 1'b0};
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31)
              state <= ST_END;
          end
        end
        ST_END: begin
          if (div_start_i) begin
            div_ready_o  <= 1'b1;
            div_result_o <= {r_fix, q_fix};
          end else begin
            state        <= ST_FREE;
            cnt          <= 5'd0;
            div_ready_o  <= 1'b0;
            div_result_o <= 64'd0;
          end
        end
        default: state <= ST_FREE;
      endcase
    end
  end

endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit integer divider serving the EX stage for DIV/DIVU. EX starts a division, holds the request while it stalls the pipeline, and collects a 64-bit {remainder, quotient} result that it forwards to HI/LO through its `hilo_t` write path. The block sits beside `ex`, between the ID/EX pipeline register and the EX/MEM pipeline register.

## Interface
- No parameters; width fixed at 32-bit operands, 64-bit result.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high (`RST_ENABLE`).
- `div_start_i`  in  1  request from EX; held high until `div_ready_o` is seen.
- `div_annul_i`  in  1  abort the in-flight division (branch or flush); takes priority over `div_start_i`.
- `div_signed_i`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- `div_oprd1_i`  in  32  dividend (rs); sampled with start.
- `div_oprd2_i`  in  32  divisor (rt); sampled with start.
- `div_result_o`  out  64  [63:32] remainder, destined for HI; [31:0] quotient, destined for LO.
- `div_ready_o`  out  1  result valid.

## Operation
- States: FREE, DIVZERO, ON, END.
- FREE:
  - If `div_start_i`=1 and `div_annul_i`=0, latch operands and `div_signed_i`.
  - Divisor = 0 → DIVZERO.
  - Otherwise → ON with iteration counter = 0.
- Signed mode:
  - Operands are converted to magnitudes before iterating.
  - After iterating, the quotient is negated when the operand signs differ; the remainder takes the dividend's sign.
  - Negation wraps modulo 2^32: 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0.
- ON: one restoring step per cycle over a 65-bit working register {partial remainder, dividend/quotient}.
  - Trial subtract partial remainder − divisor (33-bit).
  - If non-negative: keep the difference and shift in quotient bit 1.
  - Otherwise: shift in 0.
  - Counter increments 0..31. After step 31 (counter = 31) → END.
  - `div_annul_i`=1 in ON → FREE, working state discarded.
- DIVZERO: → END next cycle with working register cleared; the result is 0 (q=0, r=0).
- END:
  - `div_ready_o`←1 and `div_result_o`←sign-corrected {r, q}.
  - Both hold while `div_start_i` stays high.
  - When `div_start_i`=0, → FREE, `div_ready_o`←0, `div_result_o`←0.
- `div_start_i` is ignored outside FREE; operand inputs may change freely after sampling.
- `div_annul_i` in FREE blocks acceptance. In END it has no effect; EX drops start.

## Timing
- Reset (async, immediate): state FREE, counter 0, `div_ready_o`=0, `div_result_o`=0, working registers 0. Reset asserted mid-division aborts it with no partial output.
- Edge E0 is the edge that samples start (state FREE). The numbered edges are then:
  - Normal path: E1..E32 perform steps 0..31, and E32 enters END. `div_ready_o` rises at E33 with the result.
  - Divide by zero: E1 enters END; `div_ready_o` rises at E2 with result 0.
- `div_ready_o` is registered; no combinational path from any input to any output.
- Deasserting `div_start_i` in the cycle where `div_ready_o`=1 returns to FREE at the next edge. A new start can be sampled one edge after that.
- Back-to-back: the minimum start-to-start spacing is 35 cycles for the normal path.
- Annul seen at any edge in ON: FREE at that edge; `div_ready_o` never rises for that request.

## Test plan
- DIVU 100 / 7, start at E0 and held → `div_ready_o`=1 at E33; result = {0x00000002, 0x0000000E}. Drop start → ready 0 and result 0 at the next edge.
- DIV −7 / 2 (0xFFFFFFF9 / 0x00000002) → result = {0xFFFFFFFF, 0xFFFFFFFD}. Also DIV 7 / −2 → {0x00000001, 0xFFFFFFFD}.
- DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}. DIVU 0xFFFFFFFF / 0x00000001 → {0, 0xFFFFFFFF}.
- Divisor 0, DIV 1234 / 0 → ready at E2, result 0. Ready stays held for 5 cycles while start is high.
- Annul at E10 → state FREE and ready never rises. A new DIVU 9 / 3 started at E12 → ready at E45 with {0, 3}.
- Reset pulsed at E20 of a division → outputs 0 immediately. After release, DIVU 50 / 5 completes with {0, 10} at the normal latency.
